// File: rtl/riscv_pkg.sv
// Shared encodings for the core's memory path.
//   F3_*      : funct3 access size / sign encodings for loads and stores
//   lsu_state_e : load/store unit FSM states
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_REQ   = 2'd1,
    LSU_RESP  = 2'd2,
    LSU_FAULT = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Request side (from the incoming instruction):
//   funct3, we, addr_lo, store_data -> be, wdata, fault
// Response side (from the registered request):
//   rd_funct3, rd_addr_lo, rdata    -> load_data
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        fault,
  input  logic [2:0]  rd_funct3,
  input  logic [1:0]  rd_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0] sb;
    sb = signed'(b);
    return sgn ? 32'(sb) : {24'b0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0] sh;
    sh = signed'(h);
    return sgn ? 32'(sh) : {16'b0, h};
  endfunction

  logic illegal;
  logic misalign;
  logic [31:0] lane;

  always_comb begin
    be       = 4'b0000;
    wdata    = store_data;
    misalign = 1'b0;
    illegal  = 1'b0;
    unique case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        be       = 4'b0011 << addr_lo;
        wdata    = {2{store_data[15:0]}};
        misalign = addr_lo[0];
      end
      F3_W: begin
        be       = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
    // Stores have no unsigned variants, so any funct3 with bit 2 set is illegal.
    if (we && funct3[2]) illegal = 1'b1;
    fault = illegal | misalign;
  end

  // Shift the addressed lane down to bit 0; a word access is always lane 0.
  assign lane = rdata >> {rd_addr_lo, 3'b000};

  always_comb begin
    load_data = lane;
    unique case (rd_funct3)
      F3_B:    load_data = ext_byte(lane[7:0], 1'b1);
      F3_BU:   load_data = ext_byte(lane[7:0], 1'b0);
      F3_H:    load_data = ext_half(lane[15:0], 1'b1);
      F3_HU:   load_data = ext_half(lane[15:0], 1'b0);
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request/acknowledge transaction per memory instruction.
// Ports:
//   I_clk, I_rst            : clock, asynchronous active-high reset
//   I_valid, I_we, I_funct3 : instruction presented, store flag, size/sign
//   I_address, I_store_data : effective address (ALU result), rs2 value
//   O_ready                 : accepting (IDLE); accept when I_valid & O_ready
//   O_done, O_fault         : one-cycle completion / fault pulses
//   O_load_data             : extended load result, held until next load
//   O_mem_*                 : registered data-memory request fields
//   I_mem_ack, I_mem_rdata  : memory completion and read word
module lsu
  import riscv_pkg::*;
(
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_valid,
  input  logic        I_we,
  input  logic [2:0]  I_funct3,
  input  logic [31:0] I_address,
  input  logic [31:0] I_store_data,
  output logic        O_ready,
  output logic        O_done,
  output logic        O_fault,
  output logic [31:0] O_load_data,
  output logic        O_mem_req,
  output logic        O_mem_we,
  output logic [31:0] O_mem_addr,
  output logic [3:0]  O_mem_be,
  output logic [31:0] O_mem_wdata,
  input  logic        I_mem_ack,
  input  logic [31:0] I_mem_rdata
);

  lsu_state_e state_q, state_d;

  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        accept;
  logic        ack_p0;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic        align_fault;
  logic [31:0] align_load;

  lsu_align u_align (
    .funct3     (I_funct3),
    .we         (I_we),
    .addr_lo    (I_address[1:0]),
    .store_data (I_store_data),
    .be         (align_be),
    .wdata      (align_wdata),
    .fault      (align_fault),
    .rd_funct3  (funct3_q),
    .rd_addr_lo (addr_lo_q),
    .rdata      (I_mem_rdata),
    .load_data  (align_load)
  );

  // Reset forces IDLE, so ready stays high while reset is held.
  assign O_ready = (state_q == LSU_IDLE);
  assign accept  = I_valid & O_ready;
  // Acks outside REQ are ignored.
  assign ack_p0  = (state_q == LSU_REQ) & I_mem_ack;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) state_q <= LSU_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LSU_IDLE:  if (accept) state_d = align_fault ? LSU_FAULT : LSU_REQ;
      LSU_REQ:   if (I_mem_ack) state_d = LSU_RESP;
      LSU_RESP:  state_d = LSU_IDLE;
      LSU_FAULT: state_d = LSU_IDLE;
      default:   state_d = LSU_IDLE;
    endcase
  end

  // Accept stage: latch request fields; ack stage: capture load result.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      O_done      <= 1'b0;
      O_fault     <= 1'b0;
      O_load_data <= 32'b0;
      O_mem_req   <= 1'b0;
      O_mem_we    <= 1'b0;
      O_mem_addr  <= 32'b0;
      O_mem_be    <= 4'b0;
      O_mem_wdata <= 32'b0;
      funct3_q    <= 3'b0;
      addr_lo_q   <= 2'b0;
    end else begin
      O_done  <= ack_p0;
      O_fault <= accept & align_fault;
      if (accept && !align_fault) begin
        O_mem_req   <= 1'b1;
        O_mem_we    <= I_we;
        O_mem_addr  <= {I_address[31:2], 2'b00};
        O_mem_be    <= align_be;
        O_mem_wdata <= align_wdata;
        funct3_q    <= I_funct3;
        addr_lo_q   <= I_address[1:0];
      end else if (ack_p0) begin
        O_mem_req <= 1'b0;
        if (!O_mem_we) O_load_data <= align_load;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_valid;
  logic        I_we;
  logic [2:0]  I_funct3;
  logic [31:0] I_address;
  logic [31:0] I_store_data;
  logic        I_mem_ack;
  logic [31:0] I_mem_rdata;
  logic        O_ready, O_done, O_fault, O_mem_req, O_mem_we;
  logic [31:0] O_load_data, O_mem_addr, O_mem_wdata;
  logic [3:0]  O_mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:255];

  logic        chk_en;
  logic        exp_ready, exp_done, exp_fault, exp_req, exp_we;
  logic [31:0] exp_load, exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  lsu dut (
    .I_clk        (I_clk),
    .I_rst        (I_rst),
    .I_valid      (I_valid),
    .I_we         (I_we),
    .I_funct3     (I_funct3),
    .I_address    (I_address),
    .I_store_data (I_store_data),
    .O_ready      (O_ready),
    .O_done       (O_done),
    .O_fault      (O_fault),
    .O_load_data  (O_load_data),
    .O_mem_req    (O_mem_req),
    .O_mem_we     (O_mem_we),
    .O_mem_addr   (O_mem_addr),
    .O_mem_be     (O_mem_be),
    .O_mem_wdata  (O_mem_wdata),
    .I_mem_ack    (I_mem_ack),
    .I_mem_rdata  (I_mem_rdata)
  );

  always #5 I_clk = ~I_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model's expected outputs.
  always @(negedge I_clk) begin
    if (chk_en) begin
      check("ready", 32'(O_ready), 32'(exp_ready));
      check("done", 32'(O_done), 32'(exp_done));
      check("fault", 32'(O_fault), 32'(exp_fault));
      check("mem_req", 32'(O_mem_req), 32'(exp_req));
      check("load_data", O_load_data, exp_load);
      if (exp_req) begin
        check("mem_we", 32'(O_mem_we), 32'(exp_we));
        check("mem_addr", O_mem_addr, exp_addr);
        check("mem_be", 32'(O_mem_be), 32'(exp_be));
        if (exp_we) check("mem_wdata", O_mem_wdata, exp_wdata);
      end
    end
  end

  // ---------------- behavioural model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic m_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = acc_size(f3);
    if (sz == 0) return 1'b1;
    if (we && sz < 4 && f3[2]) return 1'b1;
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    int m;
    sz = acc_size(f3);
    m = (1 << sz) - 1;
    return 4'(m << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz;
    sz = acc_size(f3);
    if (sz == 1) return {24'b0, d[7:0]} * 32'h0101_0101;
    if (sz == 2) return {16'b0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] word);
    logic [31:0] v;
    int sz;
    sz = acc_size(f3);
    v = word >> (8 * int'(a[1:0]));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  // Runs one op starting just after an edge in an idle cycle; returns just after
  // the edge that brings the unit back to ready.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int waits, input logic busy_valid);
    logic        f;
    logic [31:0] word;
    logic [3:0]  be;
    logic [31:0] wd;
    f = m_fault(we, f3, a);
    I_valid = 1'b1; I_we = we; I_funct3 = f3; I_address = a; I_store_data = d;
    @(posedge I_clk); #1;
    if (busy_valid) begin
      I_we = ~we; I_funct3 = 3'b010; I_address = 32'h40; I_store_data = 32'h5555_5555;
    end else begin
      I_valid = 1'b0;
    end
    exp_ready = 1'b0;
    if (f) begin
      exp_fault = 1'b1;
      @(posedge I_clk); #1;
      exp_fault = 1'b0;
    end else begin
      be = m_be(f3, a);
      wd = m_wdata(f3, d);
      exp_req = 1'b1; exp_we = we; exp_addr = {a[31:2], 2'b00};
      exp_be = be; exp_wdata = wd;
      word = mem[a[9:2]];
      I_mem_rdata = word;
      for (int i = 0; i <= waits; i++) begin
        I_mem_ack = (i == waits);
        @(posedge I_clk); #1;
      end
      I_mem_ack = 1'b0;
      I_mem_rdata = 32'h0BAD_0BAD;
      exp_req = 1'b0;
      exp_done = 1'b1;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
        mem[a[9:2]] = word;
      end else begin
        exp_load = m_load(f3, a, word);
      end
      @(posedge I_clk); #1;
      exp_done = 1'b0;
    end
    I_valid = 1'b0;
    exp_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    I_rst = 1'b1; I_valid = 1'b0; I_we = 1'b0; I_funct3 = 3'b0;
    I_address = 32'h0; I_store_data = 32'h0; I_mem_ack = 1'b0; I_mem_rdata = 32'h0;
    exp_ready = 1'b1; exp_done = 1'b0; exp_fault = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    exp_load = 32'h0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_be = 4'h0;
    chk_en = 1'b1;
    #3;
    check("reset_ready", 32'(O_ready), 32'd1);
    check("reset_req", 32'(O_mem_req), 32'd0);
    @(posedge I_clk); #1;
    I_rst = 1'b0;
    @(posedge I_clk); #1;

    // LW zero-wait
    mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    do_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0);
    check("lw_literal", O_load_data, 32'hDEAD_BEEF);

    // LB / LBU sign handling
    mem[32'h100 >> 2] = 32'h80FF_FFFF;
    do_op(1'b0, 3'b000, 32'h103, 32'h0, 0, 1'b0);
    check("lb_literal", O_load_data, 32'hFFFF_FF80);
    do_op(1'b0, 3'b100, 32'h103, 32'h0, 0, 1'b0);
    check("lbu_literal", O_load_data, 32'h0000_0080);

    // SH with two wait cycles, then read the word back
    mem[32'h200 >> 2] = 32'h0000_0000;
    do_op(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 2, 1'b0);
    do_op(1'b0, 3'b010, 32'h200, 32'h0, 0, 1'b0);
    check("sh_readback", O_load_data, 32'hABCD_0000);

    // Misaligned and illegal ops: fault, no request, load data kept
    do_op(1'b0, 3'b010, 32'h101, 32'h0, 0, 1'b0);
    check("flt_lw_keep", O_load_data, 32'hABCD_0000);
    do_op(1'b0, 3'b001, 32'h003, 32'h0, 0, 1'b0);
    check("flt_lh_keep", O_load_data, 32'hABCD_0000);
    do_op(1'b1, 3'b100, 32'h300, 32'h77, 0, 1'b0);
    do_op(1'b0, 3'b011, 32'h300, 32'h0, 0, 1'b0);

    // SB then LB / LHU on other lanes
    mem[32'h300 >> 2] = 32'h1122_3344;
    do_op(1'b1, 3'b000, 32'h301, 32'h0000_00A5, 1, 1'b0);
    do_op(1'b0, 3'b000, 32'h301, 32'h0, 0, 1'b0);
    check("sb_lb_literal", O_load_data, 32'hFFFF_FFA5);
    do_op(1'b0, 3'b101, 32'h302, 32'h0, 1, 1'b0);
    check("lhu_literal", O_load_data, 32'h0000_1122);
    do_op(1'b0, 3'b001, 32'h300, 32'h0, 0, 1'b0);
    check("lh_literal", O_load_data, 32'hFFFF_A544);

    // Reset in the second REQ cycle
    mem[32'h100 >> 2] = 32'h80FF_FFFF;
    I_valid = 1'b1; I_we = 1'b0; I_funct3 = 3'b010; I_address = 32'h100;
    @(posedge I_clk); #1;
    I_valid = 1'b0;
    exp_ready = 1'b0; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h100; exp_be = 4'hF;
    I_mem_rdata = mem[32'h100 >> 2];
    @(posedge I_clk); #1;
    #2;
    I_rst = 1'b1;
    exp_req = 1'b0; exp_ready = 1'b1; exp_load = 32'h0;
    #1;
    check("rst_req_drop", 32'(O_mem_req), 32'd0);
    check("rst_ready", 32'(O_ready), 32'd1);
    @(posedge I_clk); #1;
    I_rst = 1'b0;
    @(posedge I_clk); #1;
    do_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0);
    check("post_rst_lw", O_load_data, 32'h80FF_FFFF);

    // Ack toggling in IDLE, then valid pulsed while busy
    for (int i = 0; i < 4; i++) begin
      I_mem_ack = ~I_mem_ack;
      @(posedge I_clk); #1;
    end
    I_mem_ack = 1'b0;
    @(posedge I_clk); #1;
    do_op(1'b0, 3'b101, 32'h102, 32'h0, 1, 1'b1);
    check("busy_lhu", O_load_data, 32'h0000_80FF);
    @(posedge I_clk); #1;
    @(posedge I_clk); #1;

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
